// File: rtl/entity_draw_seq.sv
// entity_draw_seq: walks a contiguous range of entity records in datapath
// memory. For each entity it reads X, then Y, then issues a plot, using the
// shared start_dp/finished_dp handshake. It can erase instead of draw, it
// skips dead slots (X all ones), and it counts the entities it plots.
module entity_draw_seq #(
  parameter int                  ADDR_W      = 8,
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  COLOUR_W    = 3,
  parameter int                  RESULT_W    = 16,
  parameter int                  INSTR_W     = 32,
  parameter int                  OP_W        = 4,
  parameter logic [OP_W-1:0]     OPC_MEMREAD = 4'd1,
  parameter logic [OP_W-1:0]     OPC_DRAW    = 4'd2,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = 8'd64,
  parameter int                  MAX_ENT     = 16,
  parameter logic [COLOUR_W-1:0] DRAW_COLOUR = 3'b100,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
  localparam int                 CNT_W       = $clog2(MAX_ENT+1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [CNT_W-1:0]    count,
  input  logic                erase,
  output logic                finished,
  output logic [CNT_W-1:0]    drawn,
  output logic                start_dp,
  output logic [INSTR_W-1:0]  instruction_dp,
  input  logic                finished_dp,
  input  logic [RESULT_W-1:0] result_dp
);

  typedef enum logic [3:0] {
    IDLE, RX_ISSUE, RX_HOLD, RX_WAIT, RY_ISSUE, RY_HOLD, RY_WAIT,
    DR_ISSUE, DR_HOLD, DR_WAIT, NEXT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     drawn_q, drawn_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic                 mode_q, mode_d;
  logic                 finished_q, finished_d;
  logic                 start_dp_q, start_dp_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  logic [CNT_W-1:0]     count_sat;
  logic [ADDR_W-1:0]    addr_x;
  logic [COLOUR_W-1:0]  colour;

  // Only the low X_W bits of the read data carry a coordinate.
  logic unused_result;
  assign unused_result = ^result_dp[RESULT_W-1:X_W];

  assign count_sat = (count > CNT_W'(MAX_ENT)) ? CNT_W'(MAX_ENT) : count;
  assign colour    = mode_q ? BG_COLOUR : DRAW_COLOUR;

  // Next-state, datapath capture and registered-output computation.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    drawn_d    = drawn_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    instr_d    = instr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = count_sat;
          mode_d  = erase;
          id_d    = '0;
          drawn_d = '0;
          // An empty run never leaves IDLE, so finished never dips.
          if (count_sat != '0) state_d = RX_ISSUE;
        end
      end
      RX_ISSUE: state_d = RX_HOLD;
      RX_HOLD:  state_d = RX_WAIT;
      RX_WAIT: begin
        if (finished_dp) begin
          x_d     = result_dp[X_W-1:0];
          // An all-ones X marks a dead slot: no Y read, no plot.
          state_d = (&result_dp[X_W-1:0]) ? NEXT : RY_ISSUE;
        end
      end
      RY_ISSUE: state_d = RY_HOLD;
      RY_HOLD:  state_d = RY_WAIT;
      RY_WAIT: begin
        if (finished_dp) begin
          y_d     = result_dp[Y_W-1:0];
          state_d = DR_ISSUE;
        end
      end
      DR_ISSUE: state_d = DR_HOLD;
      DR_HOLD:  state_d = DR_WAIT;
      DR_WAIT: begin
        if (finished_dp) begin
          drawn_d = drawn_q + 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (CNT_W'(id_q + 1'b1) == cnt_q) begin
          state_d = IDLE;
        end else begin
          id_d    = id_q + 1'b1;
          state_d = RX_ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the state being entered so they are
    // valid from the first cycle of that state.
    addr_x     = BASE_ADDR + (ADDR_W'(id_d) << 1);
    finished_d = (state_d == IDLE);
    start_dp_d = (state_d == RX_ISSUE) || (state_d == RX_HOLD) ||
                 (state_d == RY_ISSUE) || (state_d == RY_HOLD) ||
                 (state_d == DR_ISSUE) || (state_d == DR_HOLD);

    case (state_d)
      RX_ISSUE: instr_d = INSTR_W'({addr_x, OPC_MEMREAD});
      RY_ISSUE: instr_d = INSTR_W'({addr_x + 1'b1, OPC_MEMREAD});
      DR_ISSUE: instr_d = INSTR_W'({1'b1, colour, y_d, x_q, OPC_DRAW});
      default:  instr_d = instr_q;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      id_q       <= '0;
      cnt_q      <= '0;
      drawn_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= 1'b0;
      finished_q <= 1'b1;
      start_dp_q <= 1'b0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      drawn_q    <= drawn_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mode_q     <= mode_d;
      finished_q <= finished_d;
      start_dp_q <= start_dp_d;
      instr_q    <= instr_d;
    end
  end

  assign finished       = finished_q;
  assign drawn          = drawn_q;
  assign start_dp       = start_dp_q;
  assign instruction_dp = instr_q;

endmodule
